// File: rtl/wb_sram_loader_pkg.sv
// Shared types and Wishbone cycle-tag constants for the SRAM loader.
package wb_sram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_sram_loader_fifo.sv
// Synchronous FIFO decoupling the input stream from the Wishbone write beats.
module wb_sram_loader_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign full    = (level == (PTR_W + 1)'(DEPTH));
    assign empty   = (level == '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_sram_loader.sv
// Wishbone incrementing-burst write master filling a contiguous SRAM region from a stream.
module wb_sram_loader
    import wb_sram_loader_pkg::*;
#(
    parameter int unsigned WB_ADDRESS_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH    = 32,
    parameter int unsigned COUNT_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WB_ADDRESS_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0]       word_count,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    input  logic [WB_DATA_WIDTH-1:0]     in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WB_ADDRESS_WIDTH-1:0]  ADR,
    output logic                         TGA,
    output logic [2:0]                   CTI,
    output logic [1:0]                   BTE,
    output logic [WB_DATA_WIDTH-1:0]     DAT_W,
    output logic                         TGD_W,
    input  logic [WB_DATA_WIDTH-1:0]     DAT_R,
    input  logic                         TGD_R,
    output logic                         CYC,
    output logic                         TGC,
    input  logic                         ERR,
    output logic [WB_DATA_WIDTH/8-1:0]   SEL,
    output logic                         STB,
    input  logic                         ACK,
    output logic                         WE
);

    localparam int unsigned BYTES    = WB_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(BYTES);
    localparam logic [WB_ADDRESS_WIDTH-1:0] ADDR_MASK = ~WB_ADDRESS_WIDTH'(BYTES - 1);

    state_t                      state;
    logic [WB_ADDRESS_WIDTH-1:0] base;
    logic [COUNT_WIDTH-1:0]      count;
    logic [COUNT_WIDTH-1:0]      accepted;
    logic [COUNT_WIDTH-1:0]      issued;
    logic [WB_DATA_WIDTH-1:0]    fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        load;
    logic                        flush;
    logic                        ack_beat;
    logic                        err_beat;
    logic                        last_beat;
    logic                        unused_inputs;

    assign unused_inputs = ^{DAT_R, TGD_R};

    assign busy      = (state != IDLE);
    assign in_ready  = (state == XFER) && !fifo_full && (accepted < count);
    assign push      = in_valid && in_ready;
    assign ack_beat  = STB && ACK && !ERR;
    assign err_beat  = STB && ERR;
    assign last_beat = (issued == count);
    assign flush     = (state == XFER) && err_beat;

    // Next beat loads on the ACK edge itself so a zero-wait slave sees one beat per cycle.
    assign load = (state == XFER) && !err_beat && !fifo_empty
                  && (!STB || (ack_beat && !last_beat));

    assign WE    = CYC;
    assign SEL   = {BYTES{CYC}};
    assign TGA   = 1'b0;
    assign TGD_W = 1'b0;
    assign TGC   = 1'b0;
    assign BTE   = BTE_LINEAR;

    wb_sram_loader_fifo #(
        .WIDTH (WB_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .flush (flush),
        .din   (in_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            count    <= '0;
            accepted <= '0;
            issued   <= '0;
            CYC      <= 1'b0;
            STB      <= 1'b0;
            ADR      <= '0;
            DAT_W    <= '0;
            CTI      <= CTI_CLASSIC;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) accepted <= accepted + COUNT_WIDTH'(1);
            if (load) begin
                ADR    <= base + (WB_ADDRESS_WIDTH'(issued) << ADDR_LSB);
                DAT_W  <= fifo_head;
                CTI    <= (issued == count - COUNT_WIDTH'(1)) ? CTI_EOB : CTI_INCR;
                STB    <= 1'b1;
                issued <= issued + COUNT_WIDTH'(1);
            end else if (ack_beat) begin
                STB <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        base     <= base_addr & ADDR_MASK;
                        count    <= word_count;
                        accepted <= '0;
                        issued   <= '0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= XFER;
                            CYC   <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    // ERR takes priority over a simultaneous ACK.
                    if (err_beat) begin
                        state <= ABORT;
                        CYC   <= 1'b0;
                        STB   <= 1'b0;
                        error <= 1'b1;
                    end else if (ack_beat && last_beat) begin
                        state <= IDLE;
                        CYC   <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_loader.sv
// Self-checking bench: stream source and Wishbone slave models against an address/data reference.
module tb_wb_sram_loader;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          busy, done, error;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] ADR;
    logic          TGA, TGD_W, TGC, CYC, STB, WE;
    logic [2:0]    CTI;
    logic [1:0]    BTE;
    logic [DW-1:0] DAT_W;
    logic [DW-1:0] DAT_R = '0;
    logic          TGD_R = 1'b0;
    logic          ERR = 1'b0;
    logic          ACK = 1'b0;
    logic [DW/8-1:0] SEL;

    always #5 clk = ~clk;

    wb_sram_loader #(
        .WB_ADDRESS_WIDTH (AW),
        .WB_DATA_WIDTH    (DW),
        .COUNT_WIDTH      (CW),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .base_addr (base_addr),
        .word_count (word_count), .busy (busy), .done (done), .error (error),
        .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
        .ADR (ADR), .TGA (TGA), .CTI (CTI), .BTE (BTE), .DAT_W (DAT_W),
        .TGD_W (TGD_W), .DAT_R (DAT_R), .TGD_R (TGD_R), .CYC (CYC), .TGC (TGC),
        .ERR (ERR), .SEL (SEL), .STB (STB), .ACK (ACK), .WE (WE)
    );

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
    } beat_t;

    beat_t         beats[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_data[$];
    int unsigned   cur_count, n_acc, src_gap, gap_left, ack_pct, done_n;
    int            err_beat, beat_no, cyc_n, done_at, ack_at, first_ack, err_at;
    bit            stall_seen, stb_no_cyc, bad_fixed, over_acc, cyc_seen;
    bit            snap_cyc, snap_stb, snap_err;
    logic [AW-1:0] err_adr;
    int            n_checks = 0;
    int            n_pass = 0;

    // Reference: beat i of a transfer lands at the aligned base plus i words, wrapping at 2^32.
    function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] b, input int unsigned i);
        return (b & ~AW'(3)) + AW'(i) * AW'(4);
    endfunction

    function automatic logic [2:0] exp_cti(input int unsigned i, input int unsigned n);
        return (i == n - 1) ? 3'b111 : 3'b010;
    endfunction

    // One negedge: observe DUT, play the slave, play the stream source.
    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (done) begin done_n++; done_at = cyc_n; end
        if (cyc_n == err_at + 1) begin snap_cyc = CYC; snap_stb = STB; snap_err = error; end
        if (CYC && !STB) stall_seen = 1'b1;
        if (STB && !CYC) stb_no_cyc = 1'b1;
        if (CYC) cyc_seen = 1'b1;
        if (STB && (WE !== 1'b1 || SEL !== '1 || BTE !== 2'b00 || TGA || TGC || TGD_W))
            bad_fixed = 1'b1;
        if (STB) begin
            ACK = 1'b0;
            ERR = 1'b0;
            if (beat_no == err_beat) begin
                ERR = 1'b1;
                ACK = 1'($urandom_range(0, 1));
                err_at = cyc_n;
                err_adr = ADR;
                err_beat = -1;
                beat_no++;
            end else if ($urandom_range(1, 100) <= ack_pct) begin
                ACK = 1'b1;
                beats.push_back('{adr: ADR, dat: DAT_W, cti: CTI});
                if (beat_no == 0) first_ack = cyc_n;
                ack_at = cyc_n;
                beat_no++;
            end
        end else begin
            ACK = 1'($urandom_range(0, 1));
            ERR = ($urandom_range(0, 7) == 0);
        end
        if (src_q.size() > 0 && gap_left == 0) begin
            in_valid = 1'b1;
            in_data = src_q[0];
            if (in_ready) begin
                if (n_acc >= cur_count) over_acc = 1'b1;
                void'(src_q.pop_front());
                n_acc++;
                gap_left = src_gap;
            end
        end else begin
            in_valid = 1'b0;
            in_data = '0;
            if (gap_left > 0) gap_left--;
        end
    endtask

    task automatic prep(input int unsigned n, input int unsigned extra, input int unsigned gap,
                        input int unsigned pct, input int eb, input bit seq, input logic [DW-1:0] first);
        beats.delete();
        src_q.delete();
        exp_data.delete();
        for (int unsigned i = 0; i < n + extra; i++) begin
            logic [DW-1:0] w;
            w = seq ? first + DW'(i) : DW'($urandom);
            src_q.push_back(w);
            if (i < n) exp_data.push_back(w);
        end
        cur_count = n; n_acc = 0; beat_no = 0; err_beat = eb; err_at = -10;
        src_gap = gap; gap_left = 0; ack_pct = pct; done_n = 0; err_adr = '0;
        stall_seen = 0; stb_no_cyc = 0; bad_fixed = 0; over_acc = 0; cyc_seen = 0;
    endtask

    task automatic start_pulse(input logic [AW-1:0] b, input logic [CW-1:0] n);
        base_addr = b;
        word_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        word_count = CW'($urandom);
    endtask

    task automatic wait_idle(output bit finished);
        finished = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (!busy) begin finished = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prep(0, 0, 0, 100, -1, 0, '0);
        tick(); tick();
        n_checks++;
        if ({busy, done, error, in_ready, CYC, STB, WE} !== 7'b0)
            $display("FAIL reset_flags got %b exp 0000000", {busy, done, error, in_ready, CYC, STB, WE});
        else n_pass++;
        n_checks++;
        if (ADR !== '0) $display("FAIL reset_adr got %h exp 0", ADR); else n_pass++;
        n_checks++;
        if (DAT_W !== '0) $display("FAIL reset_dat got %h exp 0", DAT_W); else n_pass++;
        n_checks++;
        if (CTI !== 3'b000) $display("FAIL reset_cti got %b exp 000", CTI); else n_pass++;
        n_checks++;
        if (SEL !== '0) $display("FAIL reset_sel got %b exp 0", SEL); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait_burst();
        bit fin;
        prep(4, 0, 0, 100, -1, 1, 32'hA0);
        start_pulse(32'h100, 16'd4);
        wait_idle(fin);
        n_checks++;
        if (!fin) $display("FAIL zw_timeout busy=%b exp 0", busy); else n_pass++;
        n_checks++;
        if (beats.size() != 4) $display("FAIL zw_beats got %0d exp 4", beats.size()); else n_pass++;
        for (int unsigned i = 0; i < 4; i++) begin
            beat_t a;
            a = (i < beats.size()) ? beats[i] : '0;
            n_checks++;
            if (a.adr !== exp_adr(32'h100, i) || a.dat !== 32'hA0 + i || a.cti !== exp_cti(i, 4))
                $display("FAIL zw_beat%0d got %h/%h/%b exp %h/%h/%b", i, a.adr, a.dat, a.cti,
                         exp_adr(32'h100, i), 32'hA0 + i, exp_cti(i, 4));
            else n_pass++;
        end
        n_checks++;
        if (done_n != 1 || done_at != ack_at + 1)
            $display("FAIL zw_done got n=%0d at=%0d exp n=1 at=%0d", done_n, done_at, ack_at + 1);
        else n_pass++;
        n_checks++;
        if (ack_at - first_ack != 3) $display("FAIL zw_rate got %0d exp 3", ack_at - first_ack);
        else n_pass++;
        n_checks++;
        if (bad_fixed) $display("FAIL zw_fixed_outputs got bad exp WE=1 SEL=1111 tags=0");
        else n_pass++;
    endtask

    task automatic test_stalled_stream();
        bit fin;
        prep(4, 2, 3, 100, -1, 0, '0);
        start_pulse(32'h100, 16'd4);
        wait_idle(fin);
        n_checks++;
        if (!fin || beats.size() != 4) $display("FAIL st_beats got %0d fin=%b exp 4", beats.size(), fin);
        else n_pass++;
        for (int unsigned i = 0; i < 4; i++) begin
            beat_t a;
            a = (i < beats.size()) ? beats[i] : '0;
            n_checks++;
            if (a.adr !== exp_adr(32'h100, i) || a.dat !== exp_data[i] || a.cti !== exp_cti(i, 4))
                $display("FAIL st_beat%0d got %h/%h/%b exp %h/%h/%b", i, a.adr, a.dat, a.cti,
                         exp_adr(32'h100, i), exp_data[i], exp_cti(i, 4));
            else n_pass++;
        end
        n_checks++;
        if (!stall_seen || stb_no_cyc) $display("FAIL st_stb_drop got stall=%b stb_no_cyc=%b exp 1/0",
                                                stall_seen, stb_no_cyc);
        else n_pass++;
        n_checks++;
        if (over_acc || n_acc != 4) $display("FAIL st_accept got %0d over=%b exp 4/0", n_acc, over_acc);
        else n_pass++;
        n_checks++;
        if (done_n != 1) $display("FAIL st_done got %0d exp 1", done_n); else n_pass++;
    endtask

    task automatic test_err();
        bit fin;
        prep(4, 0, 0, 100, 1, 0, '0);
        start_pulse(32'h100, 16'd4);
        wait_idle(fin);
        tick(); tick();
        n_checks++;
        if (!fin || err_adr !== 32'h104) $display("FAIL err_adr got %h exp 00000104", err_adr);
        else n_pass++;
        n_checks++;
        if ({snap_cyc, snap_stb, snap_err} !== 3'b001)
            $display("FAIL err_next_edge got cyc/stb/err=%b exp 001", {snap_cyc, snap_stb, snap_err});
        else n_pass++;
        n_checks++;
        if (done_n != 0 || beats.size() != 1)
            $display("FAIL err_no_done got done=%0d beats=%0d exp 0/1", done_n, beats.size());
        else n_pass++;
        n_checks++;
        if (error !== 1'b1 || CYC !== 1'b0) $display("FAIL err_sticky got %b cyc=%b exp 1/0", error, CYC);
        else n_pass++;
        prep(1, 0, 0, 100, -1, 0, '0);
        start_pulse(32'h40, 16'd1);
        n_checks++;
        if (error !== 1'b0) $display("FAIL err_clear got %b exp 0", error); else n_pass++;
        wait_idle(fin);
        n_checks++;
        if (!fin || done_n != 1 || beats.size() != 1 || beats[0].adr !== 32'h40)
            $display("FAIL err_recover got done=%0d beats=%0d exp 1/1", done_n, beats.size());
        else n_pass++;
    endtask

    task automatic test_count_zero();
        prep(0, 2, 0, 100, -1, 0, '0);
        start_pulse(32'h500, 16'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL cz_done got done=%b busy=%b exp 1/0", done, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL cz_pulse got %b exp 0", done); else n_pass++;
        repeat (5) tick();
        n_checks++;
        if (cyc_seen || n_acc != 0) $display("FAIL cz_no_bus got cyc=%b acc=%0d exp 0/0", cyc_seen, n_acc);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit fin;
        prep(6, 0, 1, 70, -1, 0, '0);
        start_pulse(32'h200, 16'd6);
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL si_busy got %b exp 1", busy); else n_pass++;
        start_pulse(32'h900, 16'd2);
        wait_idle(fin);
        n_checks++;
        if (!fin || beats.size() != 6 || done_n != 1)
            $display("FAIL si_count got %0d done=%0d exp 6/1", beats.size(), done_n);
        else n_pass++;
        for (int unsigned i = 0; i < 6; i++) begin
            beat_t a;
            a = (i < beats.size()) ? beats[i] : '0;
            n_checks++;
            if (a.adr !== exp_adr(32'h200, i) || a.dat !== exp_data[i] || a.cti !== exp_cti(i, 6))
                $display("FAIL si_beat%0d got %h/%h/%b exp %h/%h/%b", i, a.adr, a.dat, a.cti,
                         exp_adr(32'h200, i), exp_data[i], exp_cti(i, 6));
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit fin;
        logic [AW-1:0] want [4];
        want = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        prep(4, 0, 0, 100, -1, 0, '0);
        start_pulse(32'hFFFF_FFF8, 16'd4);
        wait_idle(fin);
        n_checks++;
        if (!fin || beats.size() != 4) $display("FAIL wr_beats got %0d exp 4", beats.size()); else n_pass++;
        for (int unsigned i = 0; i < 4; i++) begin
            beat_t a;
            a = (i < beats.size()) ? beats[i] : '0;
            n_checks++;
            if (a.adr !== want[i] || a.dat !== exp_data[i])
                $display("FAIL wr_beat%0d got %h/%h exp %h/%h", i, a.adr, a.dat, want[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        prep(4, 0, 1, 100, -1, 0, '0);
        start_pulse(32'h300, 16'd4);
        for (int t = 0; t < 100 && beats.size() < 1; t++) tick();
        n_checks++;
        if (beats.size() < 1) $display("FAIL rm_first_beat got %0d exp 1", beats.size()); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, error, in_ready, CYC, STB, WE} !== 7'b0 || ADR !== '0 || DAT_W !== '0
            || CTI !== 3'b000 || SEL !== '0)
            $display("FAIL rm_outputs got %b adr=%h dat=%h cti=%b sel=%b exp all 0",
                     {busy, done, error, in_ready, CYC, STB, WE}, ADR, DAT_W, CTI, SEL);
        else n_pass++;
        rst = 1'b0;
        prep(5, 0, 0, 80, -1, 0, '0);
        tick();
        start_pulse(32'h400, 16'd5);
        wait_idle(fin);
        n_checks++;
        if (!fin || beats.size() != 5 || done_n != 1)
            $display("FAIL rm_fresh got %0d done=%0d exp 5/1", beats.size(), done_n);
        else n_pass++;
        for (int unsigned i = 0; i < 5; i++) begin
            beat_t a;
            a = (i < beats.size()) ? beats[i] : '0;
            n_checks++;
            if (a.adr !== exp_adr(32'h400, i) || a.dat !== exp_data[i] || a.cti !== exp_cti(i, 5))
                $display("FAIL rm_beat%0d got %h/%h/%b exp %h/%h/%b", i, a.adr, a.dat, a.cti,
                         exp_adr(32'h400, i), exp_data[i], exp_cti(i, 5));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            bit fin;
            logic [AW-1:0] b;
            int unsigned n;
            b = $urandom;
            n = $urandom_range(1, 10);
            prep(n, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(30, 100), -1, 0, '0);
            start_pulse(b, CW'(n));
            wait_idle(fin);
            n_checks++;
            if (!fin || beats.size() != n || done_n != 1 || over_acc)
                $display("FAIL rnd%0d_count got %0d done=%0d exp %0d/1", it, beats.size(), done_n, n);
            else n_pass++;
            for (int unsigned i = 0; i < n; i++) begin
                beat_t a;
                a = (i < beats.size()) ? beats[i] : '0;
                n_checks++;
                if (a.adr !== exp_adr(b, i) || a.dat !== exp_data[i] || a.cti !== exp_cti(i, n))
                    $display("FAIL rnd%0d_beat%0d got %h/%h/%b exp %h/%h/%b", it, i, a.adr, a.dat,
                             a.cti, exp_adr(b, i), exp_data[i], exp_cti(i, n));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_burst();
        test_stalled_stream();
        test_err();
        test_count_zero();
        test_start_ignored();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
